// File: rtl/uart_kernel_sysid_checker_pkg.sv
// Shared constants for the sysid boot checker: FSM encodings, sysid word
// addresses and the default expected ID/timestamp values.
package uart_kernel_sysid_checker_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ID   = 3'd1;
  localparam logic [2:0] ST_WAIT_ID = 3'd2;
  localparam logic [2:0] ST_RD_TS   = 3'd3;
  localparam logic [2:0] ST_WAIT_TS = 3'd4;
  localparam logic [2:0] ST_CHECK   = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1599482139;

  function automatic logic is_read_state(input logic [2:0] s);
    return (s == ST_RD_ID) || (s == ST_RD_TS);
  endfunction

endpackage

// File: rtl/uart_kernel_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
interface uart_kernel_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;

  modport master (output avm_address, output avm_read, input avm_readdata);
  modport slave  (input avm_address, input avm_read, output avm_readdata);
endinterface

// File: rtl/uart_kernel_sysid_read_port.sv
// Single-access read port: strobes avm_read for the cycle 'go' is high,
// then flags the readdata sample READ_LATENCY cycles later.
module uart_kernel_sysid_read_port
  import uart_kernel_sysid_checker_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               go,
  input  logic                               addr,
  uart_kernel_sysid_checker_if.master        avm,
  output logic [31:0]                        data,
  output logic                               data_valid
);

  localparam int unsigned LAST = (READ_LATENCY == 0) ? 0 : READ_LATENCY - 1;
  localparam logic [2:0]  LAST_CNT = 3'(LAST);

  logic       addr_q;
  logic       pending;
  logic [2:0] lat_cnt;

  // Address is presented combinationally in the strobe cycle and then held,
  // so it only changes on entry to a read state.
  assign avm.avm_read    = go;
  assign avm.avm_address = go ? addr : addr_q;
  assign data            = avm.avm_readdata;

  // Sample point: the strobe cycle itself for zero latency, else LAST cycles into the wait.
  always_comb begin
    data_valid = 1'b0;
    if (READ_LATENCY == 0) data_valid = go;
    else                   data_valid = pending && (lat_cnt == LAST_CNT);
  end

  // Latency counter and held address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= ADDR_ID;
      pending <= 1'b0;
      lat_cnt <= '0;
    end else if (go) begin
      addr_q  <= addr;
      lat_cnt <= '0;
      pending <= (READ_LATENCY != 0);
    end else if (pending) begin
      if (data_valid) pending <= 1'b0;
      else            lat_cnt <= lat_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/uart_kernel_sysid_checker.sv
// Boot-time sysid checker: reads ID and timestamp words, compares them with
// the expected values, retries on mismatch and publishes pass/fail.
module uart_kernel_sysid_checker
  import uart_kernel_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID  = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS  = DEFAULT_EXPECTED_TS,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_RETRIES  = 3,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  uart_kernel_sysid_checker_if.master avm,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        fail,
  output logic [31:0]                 id_value,
  output logic [31:0]                 ts_value,
  output logic [3:0]                  retry_count
);

  localparam logic [3:0] MAX_R = 4'(MAX_RETRIES);

  logic [2:0]  state;
  logic        auto_armed;
  logic        go;
  logic        rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        launch;
  logic        match;

  // Read control and launch decode.
  always_comb begin
    go      = is_read_state(state);
    rd_addr = (state == ST_RD_TS) ? ADDR_TS : ADDR_ID;
    launch  = (start || auto_armed) && ((state == ST_IDLE) || (state == ST_DONE));
    match   = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
  end

  uart_kernel_sysid_read_port #(
    .READ_LATENCY (READ_LATENCY)
  ) u_read_port (
    .clock      (clock),
    .reset_n    (reset_n),
    .go         (go),
    .addr       (rd_addr),
    .avm        (avm),
    .data       (rd_data),
    .data_valid (rd_valid)
  );

  // Sequencer FSM with status and captured words.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      auto_armed  <= AUTO_START;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      retry_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (launch) begin
            auto_armed  <= 1'b0;
            retry_count <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_RD_ID;
          end
        end
        ST_RD_ID, ST_WAIT_ID: begin
          if (rd_valid) begin
            id_value <= rd_data;
            state    <= ST_RD_TS;
          end else begin
            state    <= ST_WAIT_ID;
          end
        end
        ST_RD_TS, ST_WAIT_TS: begin
          if (rd_valid) begin
            ts_value <= rd_data;
            state    <= ST_CHECK;
          end else begin
            state    <= ST_WAIT_TS;
          end
        end
        ST_CHECK: begin
          if (match) begin
            pass  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else if (retry_count < MAX_R) begin
            retry_count <= retry_count + 4'd1;
            state       <= ST_RD_ID;
          end else begin
            fail  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
